// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, register-address width
// and the all-zero control word the ID/EX register loads when a bubble is inserted.
package pipe_ctrl_pkg;

   localparam int REG_W = 4;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      MEM_WAIT    = 2'd1,
      TIMEOUT_ERR = 2'd2
   } hsu_state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
      logic [3:0] alu_op;
   } idex_ctrl_t;

   // A bubble must not write anything back, so every control bit is cleared.
   localparam idex_ctrl_t IDEX_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for the pipeline performance statistics; it sticks at
// all-ones rather than wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard control: load-use stalls, taken-branch flushes, data-memory
// wait holds with a watchdog, and saturating stall/flush counters.
module hazard_stall_unit #(
   parameter int REG_W   = pipe_ctrl_pkg::REG_W,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_op1,
   input  logic [REG_W-1:0] id_op2,
   input  logic             id_uses_op1,
   input  logic             id_uses_op2,
   input  logic [REG_W-1:0] ie_rd,
   input  logic             ie_mem_read,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import pipe_ctrl_pkg::*;

   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   hsu_state_t        state, state_next;
   logic [WAIT_W-1:0] wait_cnt, wait_next;
   logic              pend_branch, pend_next;
   logic              load_use;
   logic              mem_hold;
   logic              err_hold;
   logic              flush_now;
   logic              lu_stall;

   assign load_use = ie_mem_read && (ie_rd != '0) &&
                     ((id_uses_op1 && (ie_rd == id_op1)) ||
                      (id_uses_op2 && (ie_rd == id_op2)));

   // Hazard priority: memory hold, then flush (new or deferred branch), then load-use.
   assign mem_hold  = !rst && mem_busy && (state != TIMEOUT_ERR);
   assign err_hold  = !rst && (state == TIMEOUT_ERR);
   assign flush_now = !rst && !mem_hold && !err_hold && (branch_taken || pend_branch);
   assign lu_stall  = !rst && !mem_hold && !err_hold && !flush_now && load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         pend_branch <= 1'b0;
      end else begin
         state       <= state_next;
         wait_cnt    <= wait_next;
         pend_branch <= pend_next;
      end
   end

   // wait_cnt holds the number of busy cycles already seen in this wait.
   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      pend_next  = pend_branch;
      case (state)
         RUN: begin
            if (mem_busy) begin
               state_next = MEM_WAIT;
               wait_next  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               if (wait_cnt == WAIT_LAST) begin
                  state_next = TIMEOUT_ERR;
               end else begin
                  wait_next = wait_cnt + 1'b1;
               end
            end else begin
               state_next = RUN;
               wait_next  = '0;
            end
         end
         TIMEOUT_ERR: begin
            state_next = TIMEOUT_ERR;
         end
         default: begin
            state_next = RUN;
            wait_next  = '0;
         end
      endcase
      if (mem_hold && branch_taken) begin
         pend_next = 1'b1;
      end else if (flush_now) begin
         pend_next = 1'b0;
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      if (mem_hold || err_hold) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
      end else if (flush_now) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (lu_stall) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   assign mem_timeout = (state == TIMEOUT_ERR);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (mem_hold || lu_stall),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (flush_now),
      .count (flush_cnt)
   );

endmodule
